// File: rtl/pcs_rx_block_lock_if.sv
// Header strobe in, lock/slip/BER status out
// between the RX gearbox and the 66b decoder.
interface pcs_rx_block_lock_if;
  logic       hdr_valid;
  logic [1:0] hdr;
  logic       pma_slip;
  logic       block_lock;
  logic       hi_ber;
  logic [5:0] ber_cnt;

  modport master (
    output hdr_valid, hdr,
    input  pma_slip, block_lock,
    input  hi_ber, ber_cnt
  );

  modport slave (
    input  hdr_valid, hdr,
    output pma_slip, block_lock,
    output hi_ber, ber_cnt
  );
endinterface

// File: rtl/pcs_rx_block_lock.sv
// 10GBASE-R RX block sync FSM with gearbox slip
// request and a windowed high-BER monitor.
module pcs_rx_block_lock #(
  parameter int unsigned SH_CNT_MAX = 64,
  parameter int unsigned INVLD_MAX  = 16,
  parameter int unsigned SLIP_WAIT  = 32,
  parameter int unsigned BER_WINDOW = 40283,
  parameter int unsigned BER_THRESH = 16
) (
  input logic               clk,
  input logic               rst,
  pcs_rx_block_lock_if.slave bus
);

  localparam int SHW = $clog2(SH_CNT_MAX + 1);
  localparam int IVW = $clog2(INVLD_MAX + 1);
  localparam int SWW = $clog2(SLIP_WAIT + 1);
  localparam int TW  = $clog2(BER_WINDOW);

  typedef enum logic [1:0] {
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_sh_cnt;
  logic [SHW-1:0]   w_sh_nxt;
  logic [SHW-1:0]   w_sh_base;
  logic [IVW-1:0]   r_invld_cnt;
  logic [IVW-1:0]   w_invld_nxt;
  logic [IVW-1:0]   w_invld_base;
  logic [SWW-1:0]   r_wait_cnt;
  logic [SWW-1:0]   w_wait_nxt;
  logic             r_lock;
  logic             w_lock_nxt;
  logic             r_slip;
  logic [TW-1:0]    r_tmr;
  logic [5:0]       r_ber_cnt;
  logic [5:0]       w_ber_inc;
  logic             r_hi_ber;
  logic             w_bad;
  logic             w_ber_act;
  logic             w_wrap;

  assign w_bad = bus.hdr_valid &&
                 (bus.hdr[1] == bus.hdr[0]);

  // FSM, header counters and lock state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RESET_CNT;
      r_sh_cnt    <= '0;
      r_invld_cnt <= '0;
      r_wait_cnt  <= '0;
      r_lock      <= 1'b0;
      r_slip      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh_cnt    <= w_sh_nxt;
      r_invld_cnt <= w_invld_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_lock      <= w_lock_nxt;
      r_slip      <= (w_state_nxt == ST_SLIP);
    end
  end

  // Next state: header evaluation, slip and realign wait
  always_comb begin
    w_state_nxt  = r_state;
    w_sh_nxt     = r_sh_cnt;
    w_invld_nxt  = r_invld_cnt;
    w_wait_nxt   = r_wait_cnt;
    w_lock_nxt   = r_lock;
    w_sh_base    = r_sh_cnt;
    w_invld_base = r_invld_cnt;
    unique case (r_state)
      ST_RESET_CNT, ST_TEST_SH: begin
        if (r_state == ST_RESET_CNT) begin
          w_sh_base    = '0;
          w_invld_base = '0;
        end
        w_state_nxt = ST_TEST_SH;
        w_sh_nxt    = w_sh_base;
        w_invld_nxt = w_invld_base;
        if (bus.hdr_valid) begin
          w_sh_nxt    = w_sh_base + SHW'(1);
          w_invld_nxt = w_invld_base + IVW'(w_bad);
          if (!r_lock) begin
            if (w_bad) begin
              w_state_nxt = ST_SLIP;
            end else if (w_sh_nxt == SHW'(SH_CNT_MAX) &&
                         w_invld_nxt == '0) begin
              w_lock_nxt  = 1'b1;
              w_sh_nxt    = '0;
              w_invld_nxt = '0;
            end
          end else if (w_invld_nxt == IVW'(INVLD_MAX)) begin
            w_lock_nxt  = 1'b0;
            w_state_nxt = ST_SLIP;
          end else if (w_sh_nxt == SHW'(SH_CNT_MAX)) begin
            w_sh_nxt    = '0;
            w_invld_nxt = '0;
          end
        end
      end
      ST_SLIP: begin
        w_lock_nxt  = 1'b0;
        w_wait_nxt  = '0;
        w_state_nxt = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        if (r_wait_cnt == SWW'(SLIP_WAIT - 1)) begin
          w_state_nxt = ST_RESET_CNT;
        end else begin
          w_wait_nxt = r_wait_cnt + SWW'(1);
        end
      end
    endcase
  end

  // Monitor stays cleared whenever lock is (or is about to be) absent
  assign w_ber_act = r_lock & w_lock_nxt;
  assign w_wrap    = (r_tmr == TW'(BER_WINDOW - 1));
  assign w_ber_inc = (r_ber_cnt == 6'd63) ? r_ber_cnt :
                     r_ber_cnt + 6'(w_bad);

  // BER window timer, saturating error count and hi_ber flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr     <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (!w_ber_act) begin
      r_tmr     <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (w_wrap) begin
      r_tmr     <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= (w_ber_inc >= 6'(BER_THRESH));
    end else begin
      r_tmr     <= r_tmr + TW'(1);
      r_ber_cnt <= w_ber_inc;
      if (w_ber_inc >= 6'(BER_THRESH)) begin
        r_hi_ber <= 1'b1;
      end
    end
  end

  assign bus.pma_slip   = r_slip;
  assign bus.block_lock = r_lock;
  assign bus.hi_ber     = r_hi_ber;
  assign bus.ber_cnt    = r_ber_cnt;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Scenario bench for pcs_rx_block_lock: lock, slip,
// lock loss, BER window and async reset cases.
module tb_pcs_rx_block_lock;

  localparam int W = 2000;

  typedef struct packed {
    logic       lock;
    logic       slip;
    logic       hi;
    logic [5:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;
  int   slips = 0;
  int   lock_edge = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  pcs_rx_block_lock_if bus ();

  pcs_rx_block_lock #(
    .SH_CNT_MAX(64),
    .INVLD_MAX (16),
    .SLIP_WAIT (32),
    .BER_WINDOW(W),
    .BER_THRESH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (bus.pma_slip === 1'b1) slips <= slips + 1;
  end

  function automatic obs_t obs();
    return {bus.block_lock, bus.pma_slip,
            bus.hi_ber, bus.ber_cnt};
  endfunction

  function automatic obs_t mk(input logic l,
      input logic s, input logic h, input int c);
    obs_t o;
    o.lock = l;
    o.slip = s;
    o.hi   = h;
    o.cnt  = 6'(c);
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] h);
    bus.hdr_valid = 1'b1;
    bus.hdr       = h;
    cyc();
    bus.hdr_valid = 1'b0;
    bus.hdr       = 2'b01;
  endtask

  task automatic wait_until(input int n);
    while (ncyc < n) cyc();
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1;
    repeat (3) cyc();
    sb.push_back(mk(0, 0, 0, 0));
    drive(2'b00);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset got=%b exp=%b", obs(), e);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    obs_t e;
    int   s0;
    s0 = slips;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(mk(i == 63, 0, 0, 0));
      drive(2'b01);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL lock[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
      cyc();
    end
    total++;
    if (slips !== s0) begin
      bad++;
      $display("FAIL lock_noslip got=%0d exp=0",
               slips - s0);
    end
  endtask

  task automatic test_invld_thresh();
    obs_t e;
    obs_t o;
    int   s0;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(mk(1, 0, 0, (i < 15) ? i + 1 : 15));
      drive((i < 15) ? 2'b11 : 2'b01);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL invld15[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
      cyc();
    end
    s0 = slips;
    for (int i = 0; i < 15; i++) begin
      sb.push_back(mk(1, 0, 1, 16 + i));
      drive(2'b11);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL invld16[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
      cyc();
    end
    drive(2'b11);
    o = obs();
    total++;
    if ({o.lock, o.slip} !== 2'b01) begin
      bad++;
      $display("FAIL loss lock/slip got=%b exp=01",
               {o.lock, o.slip});
    end
    sb.push_back(mk(0, 0, 0, 0));
    cyc();
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL loss_after got=%b exp=%b", obs(), e);
    end
    repeat (3) cyc();
    total++;
    if (slips - s0 !== 1) begin
      bad++;
      $display("FAIL loss_pulses got=%0d exp=1",
               slips - s0);
    end
  endtask

  task automatic test_slip_unlocked();
    obs_t e;
    int   s0;
    repeat (40) cyc();
    s0 = slips;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01);
      cyc();
    end
    sb.push_back(mk(0, 1, 0, 0));
    drive(2'b00);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL slip_pulse got=%b exp=%b", obs(), e);
    end
    sb.push_back(mk(0, 0, 0, 0));
    cyc();
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL slip_end got=%b exp=%b", obs(), e);
    end
    for (int i = 0; i < 32; i++) begin
      sb.push_back(mk(0, 0, 0, 0));
      drive(2'b00);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL slip_wait[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
    end
    for (int i = 0; i < 64; i++) begin
      sb.push_back(mk(i == 63, 0, 0, 0));
      drive(2'b01);
      e = sb.pop_front();
      if (i == 63) lock_edge = ncyc;
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL relock[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
      if (i != 63) cyc();
    end
    total++;
    if (slips - s0 !== 1) begin
      bad++;
      $display("FAIL slip_count got=%0d exp=1",
               slips - s0);
    end
  endtask

  task automatic test_ber_window();
    obs_t e;
    int   n;
    n = 0;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 64; k++) begin
        if (k < 2) n++;
        sb.push_back(mk(1, 0, n >= 16, n));
        drive((k < 2) ? 2'b11 : 2'b01);
        e = sb.pop_front();
        total++;
        if (obs() !== e) begin
          bad++;
          $display("FAIL ber[%0d] got=%b exp=%b",
                   w * 64 + k, obs(), e);
        end
      end
    end
    wait_until(lock_edge + W - 1);
    sb.push_back(mk(1, 0, 1, 16));
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ber_prewrap got=%b exp=%b", obs(), e);
    end
    sb.push_back(mk(1, 0, 1, 0));
    cyc();
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ber_wrap1 got=%b exp=%b", obs(), e);
    end
    wait_until(lock_edge + 2 * W - 1);
    sb.push_back(mk(1, 0, 1, 0));
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ber_hold got=%b exp=%b", obs(), e);
    end
    sb.push_back(mk(1, 0, 0, 0));
    cyc();
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL ber_clear got=%b exp=%b", obs(), e);
    end
  endtask

  task automatic test_wrap_edge();
    obs_t e;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(mk(1, 0, 0, (i < 15) ? i + 1 : 15));
      drive((i < 15) ? 2'b11 : 2'b01);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL wrap_fill[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
    end
    wait_until(lock_edge + 3 * W - 1);
    sb.push_back(mk(1, 0, 0, 15));
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL wrap_pre got=%b exp=%b", obs(), e);
    end
    sb.push_back(mk(1, 0, 1, 0));
    drive(2'b11);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL wrap_hit got=%b exp=%b", obs(), e);
    end
    sb.push_back(mk(1, 0, 1, 0));
    cyc();
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL wrap_after got=%b exp=%b", obs(), e);
    end
  endtask

  task automatic test_rst_mid();
    obs_t e;
    int   s0;
    sb.push_back(mk(0, 0, 0, 0));
    rst = 1'b1;
    #1;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rst_locked got=%b exp=%b", obs(), e);
    end
    repeat (2) cyc();
    rst = 1'b0;
    sb.push_back(mk(0, 1, 0, 0));
    drive(2'b00);
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rst_first_hdr got=%b exp=%b",
               obs(), e);
    end
    sb.push_back(mk(0, 0, 0, 0));
    rst = 1'b1;
    #1;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rst_in_slip got=%b exp=%b", obs(), e);
    end
    repeat (2) cyc();
    rst = 1'b0;
    drive(2'b00);
    cyc();
    repeat (10) cyc();
    sb.push_back(mk(0, 0, 0, 0));
    rst = 1'b1;
    #1;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL rst_in_wait got=%b exp=%b", obs(), e);
    end
    repeat (2) cyc();
    rst = 1'b0;
    s0 = slips;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(mk(i == 63, 0, 0, 0));
      drive(2'b01);
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL rst_relock[%0d] got=%b exp=%b",
                 i, obs(), e);
      end
      cyc();
    end
    total++;
    if (slips !== s0) begin
      bad++;
      $display("FAIL rst_noslip got=%0d exp=0",
               slips - s0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  initial begin
    bus.hdr_valid = 1'b0;
    bus.hdr       = 2'b01;
    test_reset();
    test_lock();
    test_invld_thresh();
    test_slip_unlocked();
    test_ber_window();
    test_wrap_edge();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcs_rx_block_lock.md
Name: pcs_rx_block_lock

Overview:
Implements the 10GBASE-R receive block-synchronisation and bit-error-rate monitor. It sits between the 32-bit PMA receive gearbox, which extracts 2-bit sync headers, and the descrambler/66b decoder. It drives the gearbox slip request until 66-bit block boundaries are found, and flags a high BER to the downstream decoder.

Parameters:
SH_CNT_MAX, 64, headers per lock-test window
INVLD_MAX, 16, invalid headers per test window that cause loss of lock
SLIP_WAIT, 32, clk cycles to ignore headers after a slip pulse (gearbox realign time), min 1
BER_WINDOW, 40283, clk cycles per BER window (125 us at 322.265625 MHz)
BER_THRESH, 16, invalid headers per BER window that set hi_ber, 1..63

Ports:
clk  in  1  receive PMA clock (gearbox word clock)
rst  in  1  asynchronous, active-high reset
hdr_valid  in  1  one-cycle strobe, one per received 66b block
hdr  in  2  sync header of that block, bit0 = first received
pma_slip  out  1  one-cycle pulse requesting a 1-bit gearbox slip
block_lock  out  1  block boundary locked
hi_ber  out  1  high bit-error rate detected
ber_cnt  out  6  invalid headers counted in the current BER window, saturating

Behaviour:
- Reset: pma_slip=0, block_lock=0, hi_ber=0, ber_cnt=0, FSM=RESET_CNT, sh_cnt=0, invld_cnt=0, window timer=0. All outputs are registered.
- Valid header: hdr==2'b01 or 2'b10. Headers 00 and 11 are invalid.
- FSM states: RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
- RESET_CNT (1 cycle): clear sh_cnt and invld_cnt, then go to TEST_SH. A hdr_valid arriving in this cycle is still evaluated, using the cleared counts.
- TEST_SH, on hdr_valid: sh_cnt+1; if the header is invalid, invld_cnt+1.
  - Unlocked, invalid header -> SLIP.
  - Unlocked, 64th header with invld_cnt==0 -> block_lock<=1 and counters clear. The lock-test window then continues in TEST_SH.
  - Locked, invld_cnt reaches INVLD_MAX -> block_lock<=0 and go to SLIP. This takes priority over sh_cnt reaching SH_CNT_MAX on the same strobe.
  - Locked, sh_cnt reaches SH_CNT_MAX with invld_cnt<INVLD_MAX -> counters clear and stay locked.
- SLIP: pma_slip=1 for exactly one cycle, block_lock=0, then go to SLIP_WAIT.
- SLIP_WAIT: ignore hdr_valid for SLIP_WAIT cycles, then go to RESET_CNT.
- Latency: block_lock and pma_slip change on the first clk edge after the deciding hdr_valid cycle. pma_slip appears exactly 1 cycle after the decision (SLIP state output).
- BER monitor, active only while block_lock=1:
  - The window timer counts clk cycles 0..BER_WINDOW-1, then wraps.
  - Each invalid header with hdr_valid increments ber_cnt, saturating at 63.
  - hi_ber<=1 on the cycle after ber_cnt reaches BER_THRESH, without waiting for the window end.
  - At window wrap: if the final count, including any invalid header on the wrap cycle, is below BER_THRESH, hi_ber<=0. In either case ber_cnt<=0.
  - While block_lock=0: window timer, ber_cnt and hi_ber are held at 0.
- rst mid-operation (including during SLIP or SLIP_WAIT): immediate return to reset values, with no residual slip pulse.

Test Plan:
- Reset, then 64 strobes of hdr=01 spaced 2 cycles apart -> block_lock=1 one cycle after the 64th strobe; pma_slip never asserted; ber_cnt=0.
- Unlocked, 4 valid headers then hdr=00 -> pma_slip high for 1 cycle, 1 cycle after the 00 strobe. The next 32 cycles of strobes are ignored. Lock then needs 64 fresh valid headers.
- Locked, 15 headers of hdr=11 within a 64-header window -> block_lock stays 1 and ber_cnt=15. Repeat with 16 -> block_lock=0 and a pma_slip pulse 1 cycle after the 16th.
- Locked, 2 invalid headers per 64-header window (lock held) -> after 16 invalid in one BER window, hi_ber=1. The following window with 0 errors -> hi_ber=0 at wrap, ber_cnt=0.
- Locked, ber_cnt=15 and an invalid header on the window-wrap cycle -> hi_ber=1 and ber_cnt=0 the next cycle.
- Assert rst 10 cycles into SLIP_WAIT -> all outputs 0 immediately. After release, normal lock is reached after 64 valid headers.
